systolic_pe_os: RTL and testbench

- Parametrised output-stationary processing element for the systolic matrix multiplier. Successor to the fixed 4-bit signed PE.
- Forwards A east and B south with valid/last tags, and multiplies and accumulates per dot product, signed or unsigned.
- Optionally saturates the accumulator and double-buffers the finished result.
- Shifts results out through a per-row drain chain, so a new tile can accumulate while the previous one drains.

---
 rtl/systolic_pkg.sv | 61 ++++++
 rtl/pe_mac_sat.sv | 43 ++++
 rtl/systolic_pe_os.sv | 161 ++++++++++++++++
 tb/tb_systolic_pe_os.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types, defaults and the overflow-aware adder for the systolic array.
package systolic_pkg;

    localparam int PE_DATA_W = 4;
    localparam int PE_ACC_W  = 12;
    // Widest accumulator sat_add can handle; operands are padded up to SAT_MAX_W+1 bits.
    localparam int SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FULL = 2'd2
    } pe_state_e;

    typedef struct packed {
        logic                 ovf;
        logic [SAT_MAX_W:0]   val;
    } sat_res_t;

    // Adds two (w+1)-bit extended operands (zero-padded to SAT_MAX_W+1 bits)
    // and returns the w-bit result, either clamped or wrapped, plus overflow.
    function automatic sat_res_t sat_add(
        input logic [SAT_MAX_W:0] a,
        input logic [SAT_MAX_W:0] b,
        input int                 w,
        input logic               is_signed,
        input logic               saturate
    );
        sat_res_t           res;
        logic [SAT_MAX_W:0] one;
        logic [SAT_MAX_W:0] mask_w;
        logic [SAT_MAX_W:0] mask_w1;
        logic [SAT_MAX_W:0] half;
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] shr_top;
        logic [SAT_MAX_W:0] shr_msb;
        logic               top;
        logic               msb;
        one     = {{SAT_MAX_W{1'b0}}, 1'b1};
        mask_w  = (one << w) - one;
        mask_w1 = (one << (w + 1)) - one;
        half    = one << (w - 1);
        sum     = (a + b) & mask_w1;
        shr_top = sum >> w;
        shr_msb = sum >> (w - 1);
        top     = shr_top[0];
        msb     = shr_msb[0];
        res.ovf = is_signed ? (top ^ msb) : top;
        if (!res.ovf || !saturate) begin
            res.val = sum & mask_w;
        end else if (!is_signed) begin
            res.val = mask_w;
        end else if (top) begin
            res.val = half;               // most negative value
        end else begin
            res.val = half - one;         // most positive value
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_mac_sat.sv
// Combinational multiply, extend, accumulate and clamp/wrap for one PE.
module pe_mac_sat
    import systolic_pkg::*;
#(
    parameter int DATA_W   = PE_DATA_W,
    parameter int ACC_W    = PE_ACC_W,
    parameter int SATURATE = 1
) (
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W:0]      prod_ext;
    logic [ACC_W:0]      acc_ext;
    logic [SAT_MAX_W:0]  prod_pad;
    logic [SAT_MAX_W:0]  acc_pad;
    sat_res_t            res;
    logic                unused_val_hi;

    // Product at full 2*DATA_W width, then extended per signedness and summed.
    always_comb begin
        prod_s   = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        prod_u   = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        prod     = signed_mode ? prod_s : prod_u;
        prod_ext = {{(ACC_W + 1 - 2*DATA_W){signed_mode & prod[2*DATA_W-1]}}, prod};
        acc_ext  = {signed_mode & acc[ACC_W-1], acc};
        prod_pad = {{(SAT_MAX_W - ACC_W){1'b0}}, prod_ext};
        acc_pad  = {{(SAT_MAX_W - ACC_W){1'b0}}, acc_ext};
        res      = sat_add(acc_pad, prod_pad, ACC_W, signed_mode, SATURATE != 0);
        sum      = res.val[ACC_W-1:0];
        ovf      = res.ovf;
    end

    assign unused_val_hi = ^res.val[SAT_MAX_W:ACC_W];

endmodule

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: forwards A/B, accumulates dot products,
// double-buffers the finished result and drains it through a per-row chain.
//
// state | meaning
// IDLE  | accumulator empty, no result held
// ACC   | accumulator holds partial terms, no result held
// FULL  | finished result held awaiting drain_load; acc may be filling again
module systolic_pe_os
    import systolic_pkg::*;
#(
    parameter int DATA_W   = PE_DATA_W,
    parameter int ACC_W    = PE_ACC_W,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] in_a,
    input  logic              in_a_valid,
    input  logic              in_a_last,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_b_valid,
    output logic [DATA_W-1:0] out_a,
    output logic              out_a_valid,
    output logic              out_a_last,
    output logic [DATA_W-1:0] out_b,
    output logic              out_b_valid,
    input  logic [ACC_W-1:0]  drain_in,
    input  logic              drain_in_valid,
    input  logic              drain_load,
    input  logic              drain_shift,
    output logic [ACC_W-1:0]  out_c,
    output logic              out_c_valid,
    output logic              res_ready,
    output logic              ovf,
    output logic              overrun
);

    if (ACC_W < 2*DATA_W || ACC_W >= SAT_MAX_W) begin : g_bad_width
        $error("systolic_pe_os: ACC_W must be >= 2*DATA_W and < SAT_MAX_W");
    end

    pe_state_e        state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic             acc_ovf, acc_ovf_nx;
    logic             acc_busy, acc_busy_nx;
    logic [ACC_W-1:0] result, result_nx;
    logic             ovf_nx;
    logic             overrun_nx;
    logic [ACC_W-1:0] mac_sum;
    logic             mac_ovf;
    logic             fire;
    logic             complete;

    // acc is zero whenever no partial terms are held, so IDLE fires start from prod.
    pe_mac_sat #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_mac (
        .signed_mode (signed_mode),
        .a           (in_a),
        .b           (in_b),
        .acc         (acc),
        .sum         (mac_sum),
        .ovf         (mac_ovf)
    );

    assign res_ready = (state == FULL);

    // A/B forwarding, one cycle, independent of MAC state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_a       <= '0;
            out_a_valid <= 1'b0;
            out_a_last  <= 1'b0;
            out_b       <= '0;
            out_b_valid <= 1'b0;
        end else begin
            out_a       <= in_a;
            out_a_valid <= in_a_valid;
            out_a_last  <= in_a_last;
            out_b       <= in_b;
            out_b_valid <= in_b_valid;
        end
    end

    // Next-state: accumulate, capture into the result buffer or flag overrun.
    always_comb begin
        fire        = in_a_valid & in_b_valid;
        complete    = fire & in_a_last;
        state_nx    = state;
        acc_nx      = acc;
        acc_ovf_nx  = acc_ovf;
        acc_busy_nx = acc_busy;
        result_nx   = result;
        ovf_nx      = ovf;
        overrun_nx  = overrun;
        if (drain_load) begin
            ovf_nx = 1'b0;
        end
        if (complete) begin
            acc_nx      = '0;
            acc_ovf_nx  = 1'b0;
            acc_busy_nx = 1'b0;
            if (state != FULL || drain_load) begin
                result_nx = mac_sum;
                ovf_nx    = acc_ovf | mac_ovf;
                state_nx  = FULL;
            end else begin
                // Old result still undrained: keep it, drop the new sum.
                overrun_nx = 1'b1;
            end
        end else begin
            if (fire) begin
                acc_nx      = mac_sum;
                acc_ovf_nx  = acc_ovf | mac_ovf;
                acc_busy_nx = 1'b1;
            end
            if (state != FULL || drain_load) begin
                state_nx = acc_busy_nx ? ACC : IDLE;
            end
        end
    end

    // MAC, result buffer and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            acc_ovf  <= 1'b0;
            acc_busy <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            acc_ovf  <= acc_ovf_nx;
            acc_busy <= acc_busy_nx;
            result   <= result_nx;
            ovf      <= ovf_nx;
            overrun  <= overrun_nx;
        end
    end

    // Drain chain register; own result takes priority over the upstream shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_c       <= '0;
            out_c_valid <= 1'b0;
        end else if (drain_load) begin
            out_c       <= result;
            out_c_valid <= res_ready;
        end else if (drain_shift) begin
            out_c       <= drain_in;
            out_c_valid <= drain_in_valid;
        end
    end

endmodule

// File: tb/tb_systolic_pe_os.sv
// Bench for systolic_pe_os: three configurations driven in lockstep and
// compared every cycle against an arithmetic model of the PE behaviour.
module tb_systolic_pe_os;

    logic        clk = 1'b0;
    logic        reset;
    logic        signed_mode;
    logic [3:0]  in_a, in_b;
    logic        in_a_valid, in_a_last, in_b_valid;
    logic [11:0] drain_in;
    logic        drain_in_valid, drain_load, drain_shift;

    logic [3:0]  out_a, out_b;
    logic        out_a_valid, out_a_last, out_b_valid;
    logic [11:0] c0;
    logic [7:0]  c1, c2;
    logic [2:0]  cv, rr, ov, orun;
    logic [3:0]  unused_a1, unused_b1, unused_a2, unused_b2;
    logic [2:0]  unused_f1, unused_f2;

    always #5 clk = ~clk;

    systolic_pe_os #(.DATA_W(4), .ACC_W(12), .SATURATE(1)) u_dut (
        .clk(clk), .reset(reset), .signed_mode(signed_mode),
        .in_a(in_a), .in_a_valid(in_a_valid), .in_a_last(in_a_last),
        .in_b(in_b), .in_b_valid(in_b_valid),
        .out_a(out_a), .out_a_valid(out_a_valid), .out_a_last(out_a_last),
        .out_b(out_b), .out_b_valid(out_b_valid),
        .drain_in(drain_in), .drain_in_valid(drain_in_valid),
        .drain_load(drain_load), .drain_shift(drain_shift),
        .out_c(c0), .out_c_valid(cv[0]), .res_ready(rr[0]), .ovf(ov[0]), .overrun(orun[0])
    );

    systolic_pe_os #(.DATA_W(4), .ACC_W(8), .SATURATE(1)) u_sat8 (
        .clk(clk), .reset(reset), .signed_mode(signed_mode),
        .in_a(in_a), .in_a_valid(in_a_valid), .in_a_last(in_a_last),
        .in_b(in_b), .in_b_valid(in_b_valid),
        .out_a(unused_a1), .out_a_valid(unused_f1[0]), .out_a_last(unused_f1[1]),
        .out_b(unused_b1), .out_b_valid(unused_f1[2]),
        .drain_in(drain_in[7:0]), .drain_in_valid(drain_in_valid),
        .drain_load(drain_load), .drain_shift(drain_shift),
        .out_c(c1), .out_c_valid(cv[1]), .res_ready(rr[1]), .ovf(ov[1]), .overrun(orun[1])
    );

    systolic_pe_os #(.DATA_W(4), .ACC_W(8), .SATURATE(0)) u_wrap8 (
        .clk(clk), .reset(reset), .signed_mode(signed_mode),
        .in_a(in_a), .in_a_valid(in_a_valid), .in_a_last(in_a_last),
        .in_b(in_b), .in_b_valid(in_b_valid),
        .out_a(unused_a2), .out_a_valid(unused_f2[0]), .out_a_last(unused_f2[1]),
        .out_b(unused_b2), .out_b_valid(unused_f2[2]),
        .drain_in(drain_in[7:0]), .drain_in_valid(drain_in_valid),
        .drain_load(drain_load), .drain_shift(drain_shift),
        .out_c(c2), .out_c_valid(cv[2]), .res_ready(rr[2]), .ovf(ov[2]), .overrun(orun[2])
    );

    // Reference model: values held as plain integers in the active number system.
    int     mw[3]   = '{12, 8, 8};
    bit     msat[3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc[3], m_res[3], m_c[3];
    bit     m_accovf[3], m_full[3], m_ovf[3], m_orun[3], m_cv[3];
    logic [3:0] e_a, e_b;
    logic       e_av, e_al, e_bv;

    int n_vec = 0;
    int n_err = 0;

    function automatic longint mask(int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint to_val(logic [3:0] x, bit sgn);
        longint v;
        v = longint'(x);
        if (sgn && x[3]) v = v - 16;
        return v;
    endfunction

    function automatic longint fit(longint s, int w, bit sgn, bit sat, output bit o);
        longint lo, hi, r;
        lo = sgn ? -(longint'(1) << (w - 1)) : 0;
        hi = sgn ? (longint'(1) << (w - 1)) - 1 : mask(w);
        r  = s;
        o  = 1'b0;
        if (s < lo || s > hi) begin
            o = 1'b1;
            if (sat) begin
                r = (s > hi) ? hi : lo;
            end else begin
                r = s & mask(w);
                if (r > hi) r = r - (longint'(1) << w);
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_res[i] = 0; m_c[i] = 0;
            m_accovf[i] = 0; m_full[i] = 0; m_ovf[i] = 0; m_orun[i] = 0; m_cv[i] = 0;
        end
        e_a = '0; e_b = '0; e_av = 1'b0; e_al = 1'b0; e_bv = 1'b0;
    endtask

    task automatic model_step();
        bit     fire, capture, o, new_ovf;
        longint p, s;
        fire = in_a_valid && in_b_valid;
        p    = to_val(in_a, signed_mode) * to_val(in_b, signed_mode);
        for (int i = 0; i < 3; i++) begin
            capture = 1'b0;
            new_ovf = 1'b0;
            if (drain_load) begin
                m_c[i]  = m_res[i];
                m_cv[i] = m_full[i];
            end else if (drain_shift) begin
                m_c[i]  = longint'(drain_in) & mask(mw[i]);
                m_cv[i] = drain_in_valid;
            end
            if (fire) begin
                s = fit(m_acc[i] + p, mw[i], signed_mode, msat[i], o);
                if (in_a_last) begin
                    if (!m_full[i] || drain_load) begin
                        m_res[i] = s;
                        new_ovf  = m_accovf[i] | o;
                        capture  = 1'b1;
                    end else begin
                        m_orun[i] = 1'b1;
                    end
                    m_acc[i]    = 0;
                    m_accovf[i] = 1'b0;
                end else begin
                    m_acc[i]    = s;
                    m_accovf[i] = m_accovf[i] | o;
                end
            end
            if (capture) begin
                m_full[i] = 1'b1;
                m_ovf[i]  = new_ovf;
            end else if (drain_load) begin
                m_full[i] = 1'b0;
                m_ovf[i]  = 1'b0;
            end
        end
        e_a = in_a; e_b = in_b; e_av = in_a_valid; e_al = in_a_last; e_bv = in_b_valid;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("c0", 64'(c0), m_c[0] & mask(12));
        chk("c1", 64'(c1), m_c[1] & mask(8));
        chk("c2", 64'(c2), m_c[2] & mask(8));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cv%0d", i),   64'(cv[i]),   64'(m_cv[i]));
            chk($sformatf("rdy%0d", i),  64'(rr[i]),   64'(m_full[i]));
            chk($sformatf("ovf%0d", i),  64'(ov[i]),   64'(m_ovf[i]));
            chk($sformatf("orun%0d", i), 64'(orun[i]), 64'(m_orun[i]));
        end
        chk("fwd_a",  64'(out_a),       64'(e_a));
        chk("fwd_av", 64'(out_a_valid), 64'(e_av));
        chk("fwd_al", 64'(out_a_last),  64'(e_al));
        chk("fwd_b",  64'(out_b),       64'(e_b));
        chk("fwd_bv", 64'(out_b_valid), 64'(e_bv));
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_a"},  64'(out_a), 64'd0);
        chk({tag, "_av"}, 64'(out_a_valid), 64'd0);
        chk({tag, "_al"}, 64'(out_a_last), 64'd0);
        chk({tag, "_b"},  64'(out_b), 64'd0);
        chk({tag, "_bv"}, 64'(out_b_valid), 64'd0);
        chk({tag, "_c0"}, 64'(c0), 64'd0);
        chk({tag, "_c1"}, 64'(c1), 64'd0);
        chk({tag, "_c2"}, 64'(c2), 64'd0);
        chk({tag, "_cv"}, 64'(cv), 64'd0);
        chk({tag, "_rr"}, 64'(rr), 64'd0);
        chk({tag, "_ov"}, 64'(ov), 64'd0);
        chk({tag, "_or"}, 64'(orun), 64'd0);
    endtask

    task automatic clr();
        in_a = '0; in_b = '0; in_a_valid = 1'b0; in_b_valid = 1'b0; in_a_last = 1'b0;
        drain_in = '0; drain_in_valid = 1'b0; drain_load = 1'b0; drain_shift = 1'b0;
    endtask

    // Inputs are set after a negedge; model advances at the posedge; outputs checked at the next negedge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic mac(int a, int b, bit last, bit dl = 1'b0);
        clr();
        in_a = 4'(a); in_b = 4'(b);
        in_a_valid = 1'b1; in_b_valid = 1'b1;
        in_a_last = last; drain_load = dl;
        step();
        clr();
    endtask

    task automatic drain();
        clr();
        drain_load = 1'b1;
        step();
        clr();
    endtask

    task automatic pulse_reset(string tag);
        reset = 1'b0;
        clr();
        #1;
        model_reset();
        chk_zero(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        signed_mode = 1'b1;
        clr();
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("rst");
        reset = 1'b1;

        // signed dot product -> -89
        mac(3, 2, 0); mac(-3, 2, 0); mac(-5, 4, 0); mac(4, -5, 0);
        mac(7, -7, 1);
        chk("sdot_rdy", 64'(rr[0]), 64'd1);
        drain();
        chk("sdot_c",   64'(c0),    64'hFA7);
        chk("sdot_cv",  64'(cv[0]), 64'd1);
        chk("sdot_ovf", 64'(ov[0]), 64'd0);
        chk("sdot_rdy0", 64'(rr[0]), 64'd0);

        // unsigned 15*15*2 = 450, then same bits signed = 2
        signed_mode = 1'b0;
        mac(15, 15, 0); mac(15, 15, 1);
        drain();
        chk("uns_c0", 64'(c0), 64'd450);
        chk("uns_c1", 64'(c1), 64'hFF);
        signed_mode = 1'b1;
        mac(15, 15, 0); mac(15, 15, 1);
        drain();
        chk("sgn_c0", 64'(c0), 64'd2);

        // saturation vs wrap on 8-bit accumulators
        mac(-8, -8, 0); mac(-8, -8, 1);
        chk("sat_ovf1", 64'(ov[1]), 64'd1);
        chk("sat_ovf2", 64'(ov[2]), 64'd1);
        chk("sat_ovf0", 64'(ov[0]), 64'd0);
        drain();
        chk("sat_c1", 64'(c1), 64'h7F);
        chk("sat_c2", 64'(c2), 64'h80);
        chk("sat_c0", 64'(c0), 64'd128);

        // overrun: second result completes while first undrained
        mac(2, 3, 1);
        mac(2, 5, 1);
        chk("orun_set", 64'(orun[0]), 64'd1);
        drain();
        chk("orun_c", 64'(c0), 64'd6);
        pulse_reset("rst2");

        // double buffer with drain_load on the completion edge
        mac(2, 3, 1);
        mac(1, 2, 0);
        mac(2, 4, 1, 1);
        chk("dbuf_c1", 64'(c0), 64'd6);
        chk("dbuf_orun", 64'(orun[0]), 64'd0);
        chk("dbuf_rdy", 64'(rr[0]), 64'd1);
        drain();
        chk("dbuf_c2", 64'(c0), 64'd10);
        // drain in FULL while acc holds partial terms
        mac(3, 3, 1);
        mac(1, 1, 0);
        drain();
        chk("part_c", 64'(c0), 64'd9);
        mac(2, 2, 1);
        drain();
        chk("part_c2", 64'(c0), 64'd5);

        // drain chain shift and priority
        clr(); drain_in = 12'h055; drain_in_valid = 1'b1; drain_shift = 1'b1;
        step(); clr();
        chk("shift_c", 64'(c0), 64'h055);
        chk("shift_cv", 64'(cv[0]), 64'd1);
        mac(1, 3, 1);
        clr(); drain_in = 12'h0AA; drain_in_valid = 1'b1; drain_shift = 1'b1; drain_load = 1'b1;
        step(); clr();
        chk("prio_c", 64'(c0), 64'd3);
        drain();
        chk("empty_cv", 64'(cv[0]), 64'd0);

        // asynchronous reset mid-tile
        mac(2, 2, 0); mac(3, 3, 0);
        #2;
        pulse_reset("rst3");
        mac(2, 3, 1);
        drain();
        chk("post_rst_c", 64'(c0), 64'd6);

        // randomized traffic, signed then unsigned
        for (int seg = 0; seg < 2; seg++) begin
            pulse_reset($sformatf("rst_seg%0d", seg));
            signed_mode = (seg == 0);
            for (int n = 0; n < 300; n++) begin
                in_a           = 4'($urandom_range(0, 15));
                in_b           = 4'($urandom_range(0, 15));
                in_a_valid     = ($urandom_range(0, 3) != 0);
                in_b_valid     = ($urandom_range(0, 3) != 0);
                in_a_last      = ($urandom_range(0, 9) < 3);
                drain_load     = ($urandom_range(0, 9) < 2);
                drain_shift    = ($urandom_range(0, 9) < 3);
                drain_in       = 12'($urandom_range(0, 4095));
                drain_in_valid = 1'($urandom_range(0, 1));
                step();
            end
            clr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
